gate_tt_checker: RTL and testbench
==================================

# gate_tt_checker

Sequential truth-table checker for the basic-gate library: drives every input combination into a combinational gate under test and reads back its output. It compares each result against a parameterized expected truth table and reports pass/fail, error count and first failing vector. It is the consuming end of the gate blocks: the gates produce `y`, and this block sweeps their inputs and checks `y` in hardware instead of a `$monitor` bench.

## Interface
- `N_IN`, 2, number of gate inputs (1..4); sweeps 2^N_IN vectors
- `EXP_TT`, 4'b1000, expected output table, width 2^N_IN; bit i = expected `y` for input vector i (default = AND)
- `SETTLE`, 2, settle cycles per vector before sampling (0..15)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a sweep; sampled only in IDLE
- `gate_y`  in  1  output of gate under test
- `stim`  out  N_IN  input vector to gate under test; bit 0 = `a`, bit 1 = `b`
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at end of sweep
- `pass`  out  1  last sweep had zero mismatches; held until next start
- `err_cnt`  out  N_IN+1  mismatch count of current/last sweep
- `first_fail`  out  N_IN  index of first mismatching vector; valid when `err_cnt != 0`
- `obs_tt`  out  2^N_IN  observed truth table (see Configuration)

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: `start`=1 → SETTLE; `idx`←0, timer←SETTLE, `err_cnt`←0, `first_fail`←0, `pass`←0, `obs_tt`←0.
- SETTLE: `stim`=`idx`; timer decrements each cycle; at 0 → SAMPLE. SETTLE=0 skips straight to SAMPLE.
- SAMPLE: compare `gate_y` with `EXP_TT[idx]`. On mismatch, `err_cnt`++ and, if `err_cnt` was 0, `first_fail`←`idx`. If `idx` = 2^N_IN−1 → DONE, else `idx`++, timer←SETTLE → SETTLE.
- DONE: `done`=1, `pass`←(`err_cnt`==0), → IDLE.
- `start` is ignored outside IDLE, including in DONE. Back-to-back sweeps are possible: `start` held high re-triggers on the first IDLE cycle.
- `err_cnt` cannot overflow (max 2^N_IN fits N_IN+1 bits).
- Reset values: `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_fail`=0, `obs_tt`=0, state IDLE.
- Reset mid-sweep aborts immediately to reset values. No partial result is retained.

## Timing
- All outputs are registered.
- `start` sampled high at edge t: `busy`=1 and `stim`=0 from cycle t+1.
- Each vector occupies SETTLE+1 cycles: SETTLE settle cycles, then 1 sample cycle.
- `gate_y` is sampled at the end of the SAMPLE cycle; `stim` is stable for the whole vector window.
- `done` is high in cycle t+1+2^N_IN·(SETTLE+1). Defaults: t+13.
- `busy` falls in the same cycle `done` rises.
- `pass`, `err_cnt`, `first_fail` are final when `done`=1 and hold until the next accepted `start`.

## Configuration
- `GATE_TT_LOG_EN` defined: in SAMPLE, `obs_tt[idx]`←`gate_y`. `obs_tt` holds the full observed table at `done`.
- `GATE_TT_LOG_EN` undefined: `obs_tt` is tied to 0, the port is still present, and no capture flops are built.

## Structure
- Package `gate_tt_pkg`: state enum (IDLE/SETTLE/SAMPLE/DONE) and expected-table constants `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_XOR`=4'b0110, `TT_NAND`=4'b0111, `TT_NOR`=4'b0001, `TT_XNOR`=4'b1001.
- One sub-module `settle_timer`: loadable down-counter with a zero flag, width 4.
- FSM, vector counter and compare logic stay in `gate_tt_checker`.

## Test plan
- Defaults, DUT = `and_gate` on `stim[0]`/`stim[1]`, `start` pulse at t → `done` at t+13, `pass`=1, `err_cnt`=0; with macro, `obs_tt`=4'b1000.
- Defaults, `gate_y` stuck at 0 → `err_cnt`=1, `first_fail`=3, `pass`=0; with macro, `obs_tt`=4'b0000.
- OR gate checked against `EXP_TT`=`TT_AND` → `err_cnt`=2, `first_fail`=1, `pass`=0; with macro, `obs_tt`=4'b1110.
- SETTLE=0, XOR gate, `EXP_TT`=`TT_XOR` → `stim` steps 0,1,2,3 on consecutive cycles, `done` at t+5, `pass`=1.
- `start` re-pulsed while `busy` → ignored: single `done`, counts unchanged vs. single sweep.
- `rst_n` low during `stim`=2 → asynchronously `busy`=0, `stim`=0, `err_cnt`=0, `pass`=0. After release, a fresh `start` yields a full correct sweep.

Source files
------------

// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg
// Shared definitions for the gate truth-table checker:
//   - state_t       : checker FSM states (IDLE/SETTLE/SAMPLE/DONE)
//   - TT_*          : expected 2-input truth tables for the basic-gate library,
//                     bit i = expected y for input vector i (bit 0 = a, bit 1 = b)
//   - num_vectors() : number of input combinations for a given input count
package gate_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    function automatic int num_vectors(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/gate_tt_checker_settle_timer.sv
// settle_timer
// Loadable down-counter with a zero flag, used to hold each stimulus vector
// for a number of settle cycles before the gate output is sampled.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   load       in   load count from load_value (has priority over dec)
//   load_value in   W  value to load
//   dec        in   decrement by one (saturates at zero)
//   zero       out  count is zero
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker
// Sweeps every input combination into a combinational gate under test, waits
// SETTLE cycles per vector, samples gate_y and compares it with EXP_TT.
// Reports pass/fail, mismatch count and first failing vector.
// Optional feature macro: GATE_TT_LOG_EN -- when defined, the observed truth
// table is captured in obs_tt; otherwise obs_tt is tied to zero.
// Parameters:
//   N_IN    number of gate inputs (1..4)
//   EXP_TT  expected truth table, bit i = expected y for vector i
//   SETTLE  settle cycles per vector before sampling (0..15)
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        request a sweep (only accepted in IDLE)
//   gate_y       output of the gate under test
//   stim         input vector to the gate under test
//   busy         sweep in progress
//   done         one-cycle pulse at end of sweep
//   pass         last sweep had no mismatches
//   err_cnt      mismatch count of current/last sweep
//   first_fail   index of first mismatching vector (valid when err_cnt != 0)
//   obs_tt       observed truth table
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]    EXP_TT = 4'b1000,
    parameter int                      SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   gate_y,
    output logic [N_IN-1:0]        stim,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_cnt,
    output logic [N_IN-1:0]        first_fail,
    output logic [(1<<N_IN)-1:0]   obs_tt
);

    // The timer is loaded with SETTLE-1 so that its zero flag marks the last
    // settle cycle, giving exactly SETTLE cycles in the SETTLE state.
    localparam logic [3:0] TIMER_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam state_t     VEC_ENTRY  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t state;
    logic   mismatch;
    logic   last_vec;
    logic   accept;
    logic   timer_load;
    logic   timer_dec;
    logic   timer_zero;

    assign accept   = (state == ST_IDLE) && start;
    assign mismatch = (gate_y != EXP_TT[stim]);
    assign last_vec = &stim;

    assign timer_load = accept || ((state == ST_SAMPLE) && !last_vec);
    assign timer_dec  = (state == ST_SETTLE);

    settle_timer #(
        .W (4)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (TIMER_LOAD),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    // Main sweep FSM. pass is computed on the final sample edge (including
    // that vector's compare) so it is already final while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= VEC_ENTRY;
                        stim       <= '0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                        first_fail <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (timer_zero) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) begin
                            first_fail <= stim;
                        end
                    end
                    if (last_vec) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0) && !mismatch;
                    end else begin
                        state <= VEC_ENTRY;
                        stim  <= stim + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GATE_TT_LOG_EN
    // Observed-table capture: cleared on an accepted start, one bit written
    // per sample cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obs_tt <= '0;
        end else if (accept) begin
            obs_tt <= '0;
        end else if (state == ST_SAMPLE) begin
            obs_tt[stim] <= gate_y;
        end
    end
`else
    assign obs_tt = '0;
`endif

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker
// Self-checking bench for gate_tt_checker. dut0 uses the default
// configuration (AND table, SETTLE=2) with a selectable gate model; dut1 uses
// SETTLE=0 against the XOR table with an XOR gate model.
module tb_gate_tt_checker;
    import gate_tt_pkg::*;

    logic       clk;
    logic       rst_n;

    logic       start0;
    logic       gate_y0;
    logic [1:0] stim0;
    logic       busy0, done0, pass0;
    logic [2:0] err_cnt0;
    logic [1:0] first_fail0;
    logic [3:0] obs_tt0;

    logic       start1;
    logic       gate_y1;
    logic [1:0] stim1;
    logic       busy1, done1, pass1;
    logic [2:0] err_cnt1;
    logic [1:0] first_fail1;
    logic [3:0] obs_tt1;

    int mode;
    int tests_run;
    int tests_failed;
    int lat;

    typedef struct {
        string      name;
        int         mode;
        logic [2:0] exp_err;
        logic [1:0] exp_ff;
        logic       exp_pass;
        logic [3:0] exp_obs;
    } vec_t;

    vec_t vecs [3];

    gate_tt_checker dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start0),
        .gate_y     (gate_y0),
        .stim       (stim0),
        .busy       (busy0),
        .done       (done0),
        .pass       (pass0),
        .err_cnt    (err_cnt0),
        .first_fail (first_fail0),
        .obs_tt     (obs_tt0)
    );

    gate_tt_checker #(
        .N_IN   (2),
        .EXP_TT (TT_XOR),
        .SETTLE (0)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .gate_y     (gate_y1),
        .stim       (stim1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .err_cnt    (err_cnt1),
        .first_fail (first_fail1),
        .obs_tt     (obs_tt1)
    );

    // Gate models: 0 = AND, 1 = stuck at 0, 2 = OR
    always_comb begin
        gate_y0 = 1'b0;
        case (mode)
            0: gate_y0 = stim0[0] & stim0[1];
            1: gate_y0 = 1'b0;
            2: gate_y0 = stim0[0] | stim0[1];
            default: gate_y0 = 1'b0;
        endcase
    end

    assign gate_y1 = stim1[0] ^ stim1[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Pulse start on dut0, check the first busy cycle, then wait (bounded)
    // for done and return the number of edges from the accepting edge.
    task automatic applyStimulus(output int latency);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        checkOutput("busy_after_start", busy0, 1'b1);
        checkOutput("stim_after_start", stim0, 2'd0);
        latency = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            latency++;
            if (done0) break;
        end
        if (!done0) checkOutput("done_timeout", done0, 1'b1);
    endtask

    function automatic logic [3:0] expObs(input logic [3:0] obs);
`ifdef GATE_TT_LOG_EN
        return obs;
`else
        return 4'b0000;
`endif
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mode         = 0;
        start0       = 1'b0;
        start1       = 1'b0;
        rst_n        = 1'b0;

        vecs[0] = '{name: "and_gate",   mode: 0, exp_err: 3'd0, exp_ff: 2'd0, exp_pass: 1'b1, exp_obs: 4'b1000};
        vecs[1] = '{name: "stuck0",     mode: 1, exp_err: 3'd1, exp_ff: 2'd3, exp_pass: 1'b0, exp_obs: 4'b0000};
        vecs[2] = '{name: "or_vs_and",  mode: 2, exp_err: 3'd2, exp_ff: 2'd1, exp_pass: 1'b0, exp_obs: 4'b1110};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_stim",   stim0,       2'd0);
        checkOutput("rst_busy",   busy0,       1'b0);
        checkOutput("rst_done",   done0,       1'b0);
        checkOutput("rst_pass",   pass0,       1'b0);
        checkOutput("rst_err",    err_cnt0,    3'd0);
        checkOutput("rst_ff",     first_fail0, 2'd0);
        checkOutput("rst_obs",    obs_tt0,     4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sweeps on the default configuration
        for (int v = 0; v < 3; v++) begin
            mode = vecs[v].mode;
            applyStimulus(lat);
            checkOutput({vecs[v].name, "_latency"}, lat, 32'd12);
            checkOutput({vecs[v].name, "_busy_at_done"}, busy0, 1'b0);
            checkOutput({vecs[v].name, "_err"}, err_cnt0, vecs[v].exp_err);
            checkOutput({vecs[v].name, "_pass"}, pass0, vecs[v].exp_pass);
            if (vecs[v].exp_err != 3'd0)
                checkOutput({vecs[v].name, "_first_fail"}, first_fail0, vecs[v].exp_ff);
            checkOutput({vecs[v].name, "_obs"}, obs_tt0, expObs(vecs[v].exp_obs));
            @(posedge clk);
            #1;
            checkOutput({vecs[v].name, "_done_pulse"}, done0, 1'b0);
            checkOutput({vecs[v].name, "_pass_hold"}, pass0, vecs[v].exp_pass);
            repeat (2) @(posedge clk);
        end

        // SETTLE=0, XOR: stim steps every cycle, done 4 edges after accept
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        checkOutput("s0_busy", busy1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("s0_stim_step", stim1, k);
            checkOutput("s0_no_done", done1, 1'b0);
            @(posedge clk);
            #1;
        end
        checkOutput("s0_done", done1, 1'b1);
        checkOutput("s0_pass", pass1, 1'b1);
        checkOutput("s0_err", err_cnt1, 3'd0);
        checkOutput("s0_obs", obs_tt1, expObs(4'b0110));

        // start re-pulsed while busy and during DONE is ignored
        mode = 2;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        lat = 6;
        for (int i = 0; i < 100; i++) begin
            if (done0) break;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("restart_latency", lat, 32'd12);
        checkOutput("restart_err", err_cnt0, 3'd2);
        checkOutput("restart_ff", first_fail0, 2'd1);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("restart_idle_busy", busy0, 1'b0);
            checkOutput("restart_idle_done", done0, 1'b0);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a sweep
        mode = 2;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (stim0 == 2'd2) break;
            @(posedge clk);
            #1;
        end
        checkOutput("mid_stim", stim0, 2'd2);
        checkOutput("mid_err", err_cnt0, 3'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", busy0, 1'b0);
        checkOutput("arst_stim", stim0, 2'd0);
        checkOutput("arst_err", err_cnt0, 3'd0);
        checkOutput("arst_pass", pass0, 1'b0);
        checkOutput("arst_obs", obs_tt0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        mode = 0;
        applyStimulus(lat);
        checkOutput("post_rst_latency", lat, 32'd12);
        checkOutput("post_rst_pass", pass0, 1'b1);
        checkOutput("post_rst_err", err_cnt0, 3'd0);
        checkOutput("post_rst_obs", obs_tt0, expObs(4'b1000));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
